// File: rtl/linia_pkg.sv
// Shared types and defaults for the linia_pomiar line-latency probe.
package linia_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND   = 2'd1,
    WAIT   = 2'd2,
    REPORT = 2'd3
  } state_e;

  // Wide all-ones word; instances slice the low N bits as their default probe.
  localparam logic [63:0] DEFAULT_PATTERN = {64{1'b1}};

endpackage

// File: rtl/linia_pomiar.sv
// Measures round-trip latency of an external line by sending a probe word and counting until it returns.
// Optional: define LINIA_POMIAR_CHECK_EN to add the err output flagging corrupted words seen while waiting.
module linia_pomiar
  import linia_pkg::*;
#(
  parameter int unsigned    N         = 2,
  parameter int unsigned    MAX_DELAY = 15,
  parameter logic [N-1:0]   PATTERN   = DEFAULT_PATTERN[N-1:0],
  localparam int unsigned   LW        = $clog2(MAX_DELAY + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic [N-1:0]  line_out,
  input  logic [N-1:0]  line_in,
  output logic          busy,
  output logic          done,
  output logic          timeout,
`ifdef LINIA_POMIAR_CHECK_EN
  output logic          err,
`endif
  output logic [LW-1:0] latency
);

  localparam logic [LW-1:0] MAX_LW = LW'(MAX_DELAY);

  state_e        state_q, state_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic [LW-1:0] lat_q, lat_d;
  logic [N-1:0]  line_out_q, line_out_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          to_q, to_d;
  logic          match_s;
  logic [LW-1:0] cnt_inc_s;
`ifdef LINIA_POMIAR_CHECK_EN
  logic          bad_q, bad_d;
  logic          err_q, err_d;
  logic          stray_s;
`endif

  assign match_s   = (line_in == PATTERN);
  assign cnt_inc_s = (cnt_q >= MAX_LW) ? MAX_LW : cnt_q + LW'(1);
`ifdef LINIA_POMIAR_CHECK_EN
  assign stray_s   = (line_in != '0) && !match_s;
`endif

  // Next-state, counter and result decode; outputs are derived from the next state so they are registered.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lat_d   = lat_q;
    done_d  = 1'b0;
    to_d    = 1'b0;
`ifdef LINIA_POMIAR_CHECK_EN
    bad_d   = bad_q;
    err_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SEND;
          cnt_d   = '0;
`ifdef LINIA_POMIAR_CHECK_EN
          bad_d   = 1'b0;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      SEND: begin
        if (match_s) begin
          state_d = REPORT;
          lat_d   = '0;
          done_d  = 1'b1;
        end else begin
          state_d = WAIT;
          cnt_d   = cnt_inc_s;
        end
      end
      WAIT: begin
        if (match_s) begin
          state_d = REPORT;
          lat_d   = cnt_q;
          done_d  = 1'b1;
`ifdef LINIA_POMIAR_CHECK_EN
          err_d   = bad_q;
`endif
        end else if (cnt_q == MAX_LW) begin
          state_d = REPORT;
          lat_d   = MAX_LW;
          to_d    = 1'b1;
        end else begin
          state_d = WAIT;
          cnt_d   = cnt_inc_s;
`ifdef LINIA_POMIAR_CHECK_EN
          bad_d   = bad_q | stray_s;
`endif
        end
      end
      REPORT: begin
        // A start arriving with the result pulse chains straight into the next probe.
        if (start) begin
          state_d = SEND;
          cnt_d   = '0;
`ifdef LINIA_POMIAR_CHECK_EN
          bad_d   = 1'b0;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    line_out_d = (state_d == SEND) ? PATTERN : '0;
    busy_d     = (state_d == SEND) || (state_d == WAIT);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      lat_q      <= '0;
      line_out_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      to_q       <= 1'b0;
`ifdef LINIA_POMIAR_CHECK_EN
      bad_q      <= 1'b0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lat_q      <= lat_d;
      line_out_q <= line_out_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      to_q       <= to_d;
`ifdef LINIA_POMIAR_CHECK_EN
      bad_q      <= bad_d;
      err_q      <= err_d;
`endif
    end
  end

  assign line_out = line_out_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign timeout  = to_q;
  assign latency  = lat_q;
`ifdef LINIA_POMIAR_CHECK_EN
  assign err      = err_q;
`endif

endmodule
